f_rat: RTL and testbench
========================

# f_rat

Front register alias table for the rename stage. Maps each architectural destination register to the ROB entry of its youngest in-flight producer. Sources are renamed against this table with intra-group bypass. Entries are cleared when the producing instruction retires out of the ROB. It sits between decode and ROB/reservation-station dispatch, consuming `is_ptr` and `rob_full` from the ROB and the ROB retire bus.

## Interface
- `ISSUE_WIDTH_MAX`, 2, rename lanes per cycle
- `ROB_MAX_RETIRE`, 4, retire lanes
- `ROB_SIZE_CLOG`, 5, ROB id width
- `SRC_LEN`, 5, architectural register index width (32 regs)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `instr_val_id`  in  IW  decode lane valid
- `rs1_id`, `rs2_id`, `rd_id`  in  IW×SRC_LEN  architectural regs
- `rfWrite_id`  in  IW  lane writes rd
- `is_ptr`  in  IW×ROB_SIZE_CLOG  ROB id allocated per lane (lane i = lane0+i)
- `rob_full`  in  1  ROB cannot accept this cycle
- `flush`  in  1  discard all mappings (mispredict/exception)
- `val_ret`, `rfWrite_ret`  in  RET  retire lane valid / writes rd
- `rd_ret`  in  RET×SRC_LEN; `robid_ret`  in  RET×ROB_SIZE_CLOG
- `val_rn`  out  IW  renamed lane valid
- `src1_pend_rn`, `src2_pend_rn`  out  IW  1 = operand comes from ROB/CDB, 0 = read ARF
- `src1_robid_rn`, `src2_robid_rn`  out  IW×ROB_SIZE_CLOG  producer ROB id (0 when not pending)
- `rd_robid_rn`  out  IW×ROB_SIZE_CLOG  registered copy of `is_ptr`
- `stall_rn`  out  1  combinational, equals `rob_full`

## Operation
- Table has 32 entries {v, robid}. x0 is never mapped. Reads of x0 always give pend=0, robid=0. Writes to rd=0 are dropped.
- acc[i] = `instr_val_id[i]` & ~`rob_full`. The whole group stalls together. There is no partial issue.
- Source lookup, lane i: search lanes j<i with acc[j] & `rfWrite_id[j]` & `rd_id[j]`==rs. The highest such j wins, giving pend=1 and robid=`is_ptr[j]`. Otherwise use the table entry.
- Retire-hit bypass: a table entry whose robid matches a retiring lane this cycle (val & rfWrite & same rd) reads as pend=0. The ARF is written on the same edge.
- Table write: for each acc lane with rfWrite and rd≠0, table[rd] ← {1, `is_ptr[i]`}. When lanes collide on the same rd, the higher lane wins.
- Retire clear: for each lane k with val & rfWrite & rd≠0, clear v only if table[rd].v and table[rd].robid==`robid_ret[k]`. A newer mapping is never cleared.
- Same-cycle rename write and retire clear to the same rd: the rename write wins.
- `flush`: clears every v and forces `val_rn`=0 next cycle. It has priority over rename and retire in that cycle.

## Timing
- Rename outputs are registered: inputs on edge N give outputs valid after edge N+1. Latency is 1 cycle.
- When `rob_full` is high, `val_rn` goes to 0 on the next edge. The table is unchanged except for retire clears.
- Retire clear is visible to lookups on the cycle after the edge, and via the bypass in the same cycle.
- Reset (asynchronous, any time including mid-group):
  - all table v=0;
  - `val_rn`, pend, robid outputs = 0.
  - The first rename is accepted on the first edge after deassertion.
- ROB id wrap-around (31→0) needs no special handling. Ids are compared for equality only.

## Structure
- Shared package (`structs.sv` / `rtl_constants.sv`):
  - `rat_entry_t` {v, robid};
  - `rn_src_t` {pend, robid};
  - `ARCH_REGS`=32.
- One sub-module, `f_rat_src_lookup`: combinational resolution of one source. Inputs are the table entry, the older lanes' rd/valid/`is_ptr`, and the retire bus. It is instantiated 2×IW.
- Everything else lives in `f_rat`: the table registers and output registers. Target is about 200 lines.

## Test plan
- Reset then lane0 reads x5 (no mapping): expect pend=0, robid=0.
- Lane0 writes x5 with `is_ptr`=3, lane1 reads rs1=x5 in the same group: lane1 pend=1, robid=3. Next cycle a read of x5 gives robid=3.
- Both lanes write x7 (`is_ptr` 8, 9): table[x7]=9. Retire robid 8 rd x7: entry stays 9. Retire robid 9: entry clears, and a later read gives pend=0.
- Rename of x4 (robid 12) in the same cycle as a retire of the old x4 mapping (robid 2): table[x4]={1,12}.
- `rob_full`=1 with both lanes valid: `val_rn`=0 and the table is unchanged. `flush` with 10 mappings live: all reads give pend=0 afterwards. `rst` low mid-stream: outputs 0 immediately.
- Lanes using x0 as rd and rs: never mapped, always pend=0.

Source files
------------

// File: rtl/f_rat_pkg.sv
// f_rat_pkg: types and constants shared by the front register alias table.
//   rat_entry_t : one table entry {v, robid}
//   rn_src_t    : one resolved source operand {pend, robid}
//   Widths: rename lanes, retire lanes, ROB id width, arch register index width.
package f_rat_pkg;

    localparam int ISSUE_WIDTH_MAX = 2;
    localparam int ROB_MAX_RETIRE  = 4;
    localparam int ROB_SIZE_CLOG   = 5;
    localparam int SRC_LEN         = 5;
    localparam int ARCH_REGS       = 32;

    typedef struct packed {
        logic                     v;
        logic [ROB_SIZE_CLOG-1:0] robid;
    } rat_entry_t;

    typedef struct packed {
        logic                     pend;
        logic [ROB_SIZE_CLOG-1:0] robid;
    } rn_src_t;

endpackage

// File: rtl/f_rat_src_lookup.sv
// f_rat_src_lookup: combinational resolution of one renamed source operand.
//   rs_i          : architectural source register
//   ent_v_i/robid : table entry currently stored for rs_i
//   older_wr_i    : per lane, lane is older than this one, accepted and writes rd
//   older_rd_i    : rd of every lane (flattened), older_ptr_i : ROB id of every lane
//   ret_wr_i      : per retire lane, valid and writes rd
//   ret_rd_i      : retire rd (flattened), ret_robid_i : retire ROB id (flattened)
//   pend_o/robid_o: 1 = operand comes from ROB/CDB with producer robid_o
module f_rat_src_lookup
    import f_rat_pkg::*;
(
    input  logic [SRC_LEN-1:0]                         rs_i,
    input  logic                                       ent_v_i,
    input  logic [ROB_SIZE_CLOG-1:0]                   ent_robid_i,
    input  logic [ISSUE_WIDTH_MAX-1:0]                 older_wr_i,
    input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]         older_rd_i,
    input  logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]   older_ptr_i,
    input  logic [ROB_MAX_RETIRE-1:0]                  ret_wr_i,
    input  logic [ROB_MAX_RETIRE*SRC_LEN-1:0]          ret_rd_i,
    input  logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0]    ret_robid_i,
    output logic                                       pend_o,
    output logic [ROB_SIZE_CLOG-1:0]                   robid_o
);

    rn_src_t res;
    logic    ret_hit;

    always_comb begin
        res     = '0;
        ret_hit = 1'b0;

        // The producer is leaving the ROB this cycle and the ARF is written on
        // the same edge, so the operand is read from the ARF.
        for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
            if (ret_wr_i[k] &&
                ret_rd_i[k*SRC_LEN +: SRC_LEN] == rs_i &&
                ret_robid_i[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] == ent_robid_i) begin
                ret_hit = 1'b1;
            end
        end

        if (ent_v_i && !ret_hit) begin
            res.pend  = 1'b1;
            res.robid = ent_robid_i;
        end

        // Ascending scan so the youngest older writer overrides.
        for (int j = 0; j < ISSUE_WIDTH_MAX; j++) begin
            if (older_wr_i[j] && older_rd_i[j*SRC_LEN +: SRC_LEN] == rs_i) begin
                res.pend  = 1'b1;
                res.robid = older_ptr_i[j*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
            end
        end

        if (rs_i == '0) begin
            res = '0;
        end
    end

    assign pend_o  = res.pend;
    assign robid_o = res.robid;

endmodule

// File: rtl/f_rat.sv
// f_rat: front register alias table for the rename stage.
//   Inputs : decode group (instr_val_id, rs1_id, rs2_id, rd_id, rfWrite_id),
//            ROB allocation ids (is_ptr), rob_full, flush, ROB retire bus
//            (val_ret, rfWrite_ret, rd_ret, robid_ret).
//   Outputs: registered rename results (val_rn, srcN_pend_rn, srcN_robid_rn,
//            rd_robid_rn) and combinational stall_rn.
//   rst is asynchronous and active-low.
module f_rat
    import f_rat_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                instr_val_id,
    input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]        rs1_id,
    input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]        rs2_id,
    input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]        rd_id,
    input  logic [ISSUE_WIDTH_MAX-1:0]                rfWrite_id,
    input  logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]  is_ptr,
    input  logic                                      rob_full,
    input  logic                                      flush,
    input  logic [ROB_MAX_RETIRE-1:0]                 val_ret,
    input  logic [ROB_MAX_RETIRE-1:0]                 rfWrite_ret,
    input  logic [ROB_MAX_RETIRE*SRC_LEN-1:0]         rd_ret,
    input  logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0]   robid_ret,
    output logic [ISSUE_WIDTH_MAX-1:0]                val_rn,
    output logic [ISSUE_WIDTH_MAX-1:0]                src1_pend_rn,
    output logic [ISSUE_WIDTH_MAX-1:0]                src2_pend_rn,
    output logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]  src1_robid_rn,
    output logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]  src2_robid_rn,
    output logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]  rd_robid_rn,
    output logic                                      stall_rn
);

    localparam int IW  = ISSUE_WIDTH_MAX;
    localparam int RET = ROB_MAX_RETIRE;
    localparam int RW  = ROB_SIZE_CLOG;
    localparam int SL  = SRC_LEN;

    // The whole group issues or stalls together.
    logic [IW-1:0]  acc;
    logic [IW-1:0]  wr_lane;
    logic [RET-1:0] ret_wr;

    assign acc      = instr_val_id & {IW{~rob_full}};
    assign wr_lane  = acc & rfWrite_id;
    assign ret_wr   = val_ret & rfWrite_ret;
    assign stall_rn = rob_full;

    rat_entry_t tbl_q [ARCH_REGS];
    rat_entry_t tbl_d [ARCH_REGS];

    // Priority per entry: flush > rename write (highest lane) > retire clear.
    // x0 is never written so it always reads unmapped.
    always_comb begin
        for (int r = 0; r < ARCH_REGS; r++) begin
            tbl_d[r] = tbl_q[r];
            if (r != 0) begin
                for (int k = 0; k < RET; k++) begin
                    if (ret_wr[k] && rd_ret[k*SL +: SL] == SL'(r) && tbl_q[r].v &&
                        tbl_q[r].robid == robid_ret[k*RW +: RW]) begin
                        tbl_d[r].v = 1'b0;
                    end
                end
                for (int i = 0; i < IW; i++) begin
                    if (wr_lane[i] && rd_id[i*SL +: SL] == SL'(r)) begin
                        tbl_d[r].v     = 1'b1;
                        tbl_d[r].robid = is_ptr[i*RW +: RW];
                    end
                end
            end
            if (flush) begin
                tbl_d[r].v = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                tbl_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                tbl_q[r] <= tbl_d[r];
            end
        end
    end

    logic [IW-1:0]    s1_pend;
    logic [IW-1:0]    s2_pend;
    logic [IW*RW-1:0] s1_robid;
    logic [IW*RW-1:0] s2_robid;

    for (genvar gi = 0; gi < IW; gi++) begin : g_lane
        // Only lanes below gi are older than lane gi.
        localparam logic [IW-1:0] OLDER = IW'((1 << gi) - 1);

        logic [SL-1:0] rs1;
        logic [SL-1:0] rs2;
        rat_entry_t    ent1;
        rat_entry_t    ent2;

        assign rs1  = rs1_id[gi*SL +: SL];
        assign rs2  = rs2_id[gi*SL +: SL];
        assign ent1 = tbl_q[rs1];
        assign ent2 = tbl_q[rs2];

        f_rat_src_lookup u_src1 (
            .rs_i        (rs1),
            .ent_v_i     (ent1.v),
            .ent_robid_i (ent1.robid),
            .older_wr_i  (wr_lane & OLDER),
            .older_rd_i  (rd_id),
            .older_ptr_i (is_ptr),
            .ret_wr_i    (ret_wr),
            .ret_rd_i    (rd_ret),
            .ret_robid_i (robid_ret),
            .pend_o      (s1_pend[gi]),
            .robid_o     (s1_robid[gi*RW +: RW])
        );

        f_rat_src_lookup u_src2 (
            .rs_i        (rs2),
            .ent_v_i     (ent2.v),
            .ent_robid_i (ent2.robid),
            .older_wr_i  (wr_lane & OLDER),
            .older_rd_i  (rd_id),
            .older_ptr_i (is_ptr),
            .ret_wr_i    (ret_wr),
            .ret_rd_i    (rd_ret),
            .ret_robid_i (robid_ret),
            .pend_o      (s2_pend[gi]),
            .robid_o     (s2_robid[gi*RW +: RW])
        );
    end

    logic [IW-1:0]    val_rn_q;
    logic [IW-1:0]    s1_pend_q;
    logic [IW-1:0]    s2_pend_q;
    logic [IW*RW-1:0] s1_robid_q;
    logic [IW*RW-1:0] s2_robid_q;
    logic [IW*RW-1:0] rd_robid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_rn_q   <= '0;
            s1_pend_q  <= '0;
            s2_pend_q  <= '0;
            s1_robid_q <= '0;
            s2_robid_q <= '0;
            rd_robid_q <= '0;
        end else begin
            val_rn_q   <= flush ? '0 : acc;
            s1_pend_q  <= s1_pend;
            s2_pend_q  <= s2_pend;
            s1_robid_q <= s1_robid;
            s2_robid_q <= s2_robid;
            rd_robid_q <= is_ptr;
        end
    end

    assign val_rn        = val_rn_q;
    assign src1_pend_rn  = s1_pend_q;
    assign src2_pend_rn  = s2_pend_q;
    assign src1_robid_rn = s1_robid_q;
    assign src2_robid_rn = s2_robid_q;
    assign rd_robid_rn   = rd_robid_q;

endmodule

// File: tb/tb_f_rat.sv
// tb_f_rat: directed and randomized checks of f_rat against a behavioural
// alias-table model (array of {valid, robid} per architectural register).
module tb_f_rat;
    import f_rat_pkg::*;

    localparam int IW  = ISSUE_WIDTH_MAX;
    localparam int RET = ROB_MAX_RETIRE;
    localparam int RW  = ROB_SIZE_CLOG;
    localparam int SL  = SRC_LEN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [IW-1:0]     instr_val_id;
    logic [IW*SL-1:0]  rs1_id, rs2_id, rd_id;
    logic [IW-1:0]     rfWrite_id;
    logic [IW*RW-1:0]  is_ptr;
    logic              rob_full, flush;
    logic [RET-1:0]    val_ret, rfWrite_ret;
    logic [RET*SL-1:0] rd_ret;
    logic [RET*RW-1:0] robid_ret;
    logic [IW-1:0]     val_rn, src1_pend_rn, src2_pend_rn;
    logic [IW*RW-1:0]  src1_robid_rn, src2_robid_rn, rd_robid_rn;
    logic              stall_rn;

    f_rat dut (
        .clk(clk), .rst(rst),
        .instr_val_id(instr_val_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rfWrite_id(rfWrite_id), .is_ptr(is_ptr), .rob_full(rob_full), .flush(flush),
        .val_ret(val_ret), .rfWrite_ret(rfWrite_ret), .rd_ret(rd_ret), .robid_ret(robid_ret),
        .val_rn(val_rn), .src1_pend_rn(src1_pend_rn), .src2_pend_rn(src2_pend_rn),
        .src1_robid_rn(src1_robid_rn), .src2_robid_rn(src2_robid_rn),
        .rd_robid_rn(rd_robid_rn), .stall_rn(stall_rn)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference alias table: youngest in-flight producer per register.
    bit         mv [32];
    logic [4:0] mr [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        instr_val_id = '0; rs1_id = '0; rs2_id = '0; rd_id = '0; rfWrite_id = '0;
        is_ptr = '0; rob_full = 1'b0; flush = 1'b0;
        val_ret = '0; rfWrite_ret = '0; rd_ret = '0; robid_ret = '0;
    endtask

    task automatic set_lane(input int i, input bit v, input int rs1, input int rs2,
                            input int rd, input bit wr, input int ptr);
        instr_val_id[i]      = v;
        rs1_id[i*SL +: SL]   = SL'(rs1);
        rs2_id[i*SL +: SL]   = SL'(rs2);
        rd_id[i*SL +: SL]    = SL'(rd);
        rfWrite_id[i]        = wr;
        is_ptr[i*RW +: RW]   = RW'(ptr);
    endtask

    task automatic set_ret(input int k, input int rd, input int robid);
        val_ret[k]             = 1'b1;
        rfWrite_ret[k]         = 1'b1;
        rd_ret[k*SL +: SL]     = SL'(rd);
        robid_ret[k*RW +: RW]  = RW'(robid);
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin mv[r] = 1'b0; mr[r] = '0; end
    endfunction

    // Operand source from the rules: x0 -> ARF; youngest older lane in the
    // group writing rs -> that lane's ROB id; live table mapping whose
    // producer is not retiring right now -> that ROB id; otherwise ARF.
    function automatic void ref_src(input int lane, input logic [4:0] rs, input logic [IW-1:0] acc,
                                    output logic p, output logic [4:0] r);
        bit retiring;
        p = 1'b0; r = '0;
        if (rs == 5'd0) return;
        for (int j = lane - 1; j >= 0; j--) begin
            if (acc[j] && rfWrite_id[j] && rd_id[j*SL +: SL] == rs) begin
                p = 1'b1; r = is_ptr[j*RW +: RW]; return;
            end
        end
        if (mv[rs]) begin
            retiring = 1'b0;
            for (int k = 0; k < RET; k++)
                if (val_ret[k] && rfWrite_ret[k] && rd_ret[k*SL +: SL] == rs &&
                    robid_ret[k*RW +: RW] == mr[rs]) retiring = 1'b1;
            if (!retiring) begin p = 1'b1; r = mr[rs]; end
        end
    endfunction

    // One rename cycle: predict, clock, update the model, compare.
    task automatic step(input string tag);
        logic [IW-1:0] acc, exp_val;
        logic          ep1 [IW], ep2 [IW];
        logic [4:0]    er1 [IW], er2 [IW];
        logic [IW*RW-1:0] exp_rd;
        bit            nv [32];
        logic [4:0]    nr [32];
        int            rd;
        #1;
        chk({tag, "_stall"}, 32'(stall_rn), 32'(rob_full));
        for (int i = 0; i < IW; i++) acc[i] = instr_val_id[i] & ~rob_full;
        for (int i = 0; i < IW; i++) begin
            ref_src(i, rs1_id[i*SL +: SL], acc, ep1[i], er1[i]);
            ref_src(i, rs2_id[i*SL +: SL], acc, ep2[i], er2[i]);
        end
        exp_val = flush ? '0 : acc;
        exp_rd  = is_ptr;
        // Next table state.
        for (int r = 0; r < 32; r++) begin nv[r] = mv[r]; nr[r] = mr[r]; end
        if (flush) begin
            for (int r = 0; r < 32; r++) nv[r] = 1'b0;
        end else begin
            for (int k = 0; k < RET; k++) begin
                rd = int'(rd_ret[k*SL +: SL]);
                if (val_ret[k] && rfWrite_ret[k] && rd != 0 && mv[rd] &&
                    mr[rd] == robid_ret[k*RW +: RW]) nv[rd] = 1'b0;
            end
            for (int i = 0; i < IW; i++) begin
                rd = int'(rd_id[i*SL +: SL]);
                if (acc[i] && rfWrite_id[i] && rd != 0) begin
                    nv[rd] = 1'b1; nr[rd] = is_ptr[i*RW +: RW];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin mv[r] = nv[r]; mr[r] = nr[r]; end
        chk({tag, "_val"}, 32'(val_rn), 32'(exp_val));
        chk({tag, "_rdrob"}, 32'(rd_robid_rn), 32'(exp_rd));
        for (int i = 0; i < IW; i++) begin
            if (exp_val[i]) begin
                chk($sformatf("%s_l%0d_p1", tag, i), 32'(src1_pend_rn[i]), 32'(ep1[i]));
                chk($sformatf("%s_l%0d_r1", tag, i), 32'(src1_robid_rn[i*RW +: RW]), 32'(er1[i]));
                chk($sformatf("%s_l%0d_p2", tag, i), 32'(src2_pend_rn[i]), 32'(ep2[i]));
                chk($sformatf("%s_l%0d_r2", tag, i), 32'(src2_robid_rn[i*RW +: RW]), 32'(er2[i]));
            end
        end
        $display("step %s val=%b p1=%b r1=%h p2=%b r2=%h", tag, val_rn,
                 src1_pend_rn, src1_robid_rn, src2_pend_rn, src2_robid_rn);
        idle();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_val"}, 32'(val_rn), 32'd0);
        chk({tag, "_pend"}, 32'({src1_pend_rn, src2_pend_rn}), 32'd0);
        chk({tag, "_robid"}, 32'({src1_robid_rn, src2_robid_rn}), 32'd0);
        chk({tag, "_rdrob"}, 32'(rd_robid_rn), 32'd0);
    endtask

    initial begin
        int p0;
        idle();
        model_clear();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b1;

        // Unmapped read.
        set_lane(0, 1, 5, 0, 0, 0, 0);
        step("unmapped");
        chk("unmapped_pend", 32'(src1_pend_rn[0]), 32'd0);

        // Intra-group bypass then table hit.
        set_lane(0, 1, 0, 0, 5, 1, 3);
        set_lane(1, 1, 5, 0, 0, 0, 4);
        step("bypass");
        chk("bypass_pend", 32'(src1_pend_rn[1]), 32'd1);
        chk("bypass_robid", 32'(src1_robid_rn[RW +: RW]), 32'd3);
        set_lane(0, 1, 5, 0, 0, 0, 5);
        step("tblhit");
        chk("tblhit_robid", 32'(src1_robid_rn[0 +: RW]), 32'd3);

        // Same-rd collision, stale retire, matching retire with bypass.
        set_lane(0, 1, 0, 0, 7, 1, 8);
        set_lane(1, 1, 0, 0, 7, 1, 9);
        step("wcoll");
        set_ret(0, 7, 8);
        set_lane(0, 1, 7, 0, 0, 0, 10);
        step("oldret");
        chk("oldret_robid", 32'(src1_robid_rn[0 +: RW]), 32'd9);
        set_ret(1, 7, 9);
        set_lane(0, 1, 7, 7, 0, 0, 11);
        step("retbyp");
        chk("retbyp_pend", 32'(src1_pend_rn[0]), 32'd0);
        set_lane(0, 1, 0, 7, 0, 0, 12);
        step("retdone");
        chk("retdone_pend", 32'(src2_pend_rn[0]), 32'd0);

        // Rename write beats retire clear on the same rd.
        set_lane(0, 1, 0, 0, 4, 1, 2);
        step("map4");
        set_ret(2, 4, 2);
        set_lane(0, 1, 0, 0, 4, 1, 12);
        step("rnwin");
        set_lane(0, 1, 4, 0, 0, 0, 13);
        step("rnwin_rd");
        chk("rnwin_robid", 32'(src1_robid_rn[0 +: RW]), 32'd12);

        // ROB full: nothing accepted, no table update.
        rob_full = 1'b1;
        set_lane(0, 1, 0, 0, 10, 1, 20);
        set_lane(1, 1, 0, 0, 10, 1, 21);
        step("robfull");
        set_lane(0, 1, 10, 0, 0, 0, 22);
        step("robfull_rd");

        // Ten live mappings then flush.
        for (int c = 0; c < 5; c++) begin
            set_lane(0, 1, 0, 0, 11 + 2 * c, 1, 2 * c);
            set_lane(1, 1, 0, 0, 12 + 2 * c, 1, 2 * c + 1);
            step("map10");
        end
        flush = 1'b1;
        set_lane(0, 1, 11, 12, 0, 0, 14);
        step("flush");
        for (int c = 0; c < 5; c++) begin
            set_lane(0, 1, 11 + 2 * c, 12 + 2 * c, 0, 0, 2 * c);
            set_lane(1, 1, 12 + 2 * c, 11 + 2 * c, 0, 0, 2 * c + 1);
            step("postflush");
        end

        // x0 is never mapped.
        set_lane(0, 1, 0, 0, 0, 1, 5);
        set_lane(1, 1, 0, 0, 0, 0, 6);
        step("x0grp");
        set_lane(0, 1, 0, 0, 0, 0, 7);
        step("x0rd");
        chk("x0_pend", 32'(src1_pend_rn[0]), 32'd0);

        // Reset in the middle of a stream.
        set_lane(0, 1, 0, 0, 6, 1, 17);
        step("premid");
        rst = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        model_clear();
        #1;
        rst = 1'b1;
        set_lane(0, 1, 6, 0, 0, 0, 18);
        step("postrst");

        // Randomized traffic on a narrow register range for frequent collisions.
        for (int n = 0; n < 400; n++) begin
            p0 = int'($urandom_range(0, 31));
            for (int i = 0; i < IW; i++)
                set_lane(i, ($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         ($urandom_range(0, 9) < 7), (p0 + i) % 32);
            rob_full = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < RET; k++) begin
                int rd;
                rd = int'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1)
                    set_ret(k, rd, $urandom_range(0, 1) == 1 ? int'(mr[rd]) : int'($urandom_range(0, 31)));
                rfWrite_ret[k] = rfWrite_ret[k] & ($urandom_range(0, 3) != 0);
            end
            step($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
